rtr_outport_sched: RTL

- Per-output-port scheduler for the 5-port NoC router.
- One instance per output port, clocked on the NoC clock.
- Shares the port among NUM_INPUTS input FIFOs using round-robin arbitration with wormhole locking: a granted packet holds the port from head through tail.
- Gates every flit transfer on a downstream credit counter and drives the port's send strobe.

---
 rtl/rtr_outport_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rtr_outport_sched.sv
// Per-output-port scheduler: round-robin arbitration with wormhole locking and
// downstream credit gating. Define RTR_OUTPORT_SCHED_STATS_EN to add packet/flit/stall counters.
module rtr_outport_sched #(
    parameter int unsigned NUM_INPUTS        = 5,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int unsigned IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   disable_mask,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    locked_idx,
`ifdef RTR_OUTPORT_SCHED_STATS_EN
    output logic [31:0]             pkt_count,
    output logic [31:0]             flit_count,
    output logic [31:0]             stall_count,
`endif
    output logic                    credit_err
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    locked_idx_q, locked_idx_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    credit_err_q, credit_err_d;

    logic [NUM_INPUTS-1:0]   eligible;
    logic                    can_send;
    logic                    pick_found;
    logic [IDX_WIDTH-1:0]    pick_idx;

    // First eligible index at or after ptr, searched cyclically; MSB flags a hit.
    function automatic logic [IDX_WIDTH:0] rr_pick(input logic [NUM_INPUTS-1:0] elig,
                                                   input logic [IDX_WIDTH-1:0]  ptr);
        logic [IDX_WIDTH:0] res;
        int unsigned        cand;
        res = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            cand = (32'(ptr) + k) % NUM_INPUTS;
            if (!res[IDX_WIDTH] && elig[IDX_WIDTH'(cand)]) begin
                res = {1'b1, IDX_WIDTH'(cand)};
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
    endfunction

    assign eligible = req & ~disable_mask;
    assign can_send = (credit_q != '0);
    assign {pick_found, pick_idx} = rr_pick(eligible, rr_ptr_q);

    // Arbitration, wormhole lock and grant generation.
    always_comb begin
        state_d      = state_q;
        locked_idx_d = locked_idx_q;
        rr_ptr_d     = rr_ptr_q;
        grant        = '0;
        if (!rst_noc_sync) begin
            case (state_q)
                IDLE: begin
                    if (can_send && pick_found) begin
                        grant[pick_idx] = 1'b1;
                        if (req_is_tail[pick_idx]) begin
                            rr_ptr_d = idx_inc(pick_idx);
                        end else begin
                            state_d      = LOCKED;
                            locked_idx_d = pick_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (req[locked_idx_q] && can_send) begin
                        grant[locked_idx_q] = 1'b1;
                        if (req_is_tail[locked_idx_q]) begin
                            state_d  = IDLE;
                            rr_ptr_d = idx_inc(locked_idx_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign send_out = |grant;

    // Credit counter: saturate on overflow and flag it.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({send_out, credit_in})
            2'b10: credit_d = credit_q - CREDIT_WIDTH'(1);
            2'b01: begin
                if (credit_q >= CREDIT_MAX) begin
                    credit_d     = CREDIT_MAX;
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CREDIT_WIDTH'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q      <= IDLE;
            locked_idx_q <= '0;
            rr_ptr_q     <= '0;
            credit_q     <= CREDIT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_idx_q <= locked_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign credit_count = credit_q;
    assign locked       = (state_q == LOCKED);
    assign locked_idx   = locked_idx_q;
    assign credit_err   = credit_err_q;

`ifdef RTR_OUTPORT_SCHED_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] flit_count_q, flit_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        pending;

    // A request is pending if the owner (when locked) or any eligible input (when idle) asks.
    always_comb begin
        pending       = (state_q == LOCKED) ? req[locked_idx_q] : (|eligible);
        pkt_count_d   = pkt_count_q + 32'(|(grant & req_is_tail));
        flit_count_d  = flit_count_q + 32'(send_out);
        stall_count_d = stall_count_q + 32'(pending && !can_send);
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            pkt_count_q   <= '0;
            flit_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            pkt_count_q   <= pkt_count_d;
            flit_count_q  <= flit_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pkt_count   = pkt_count_q;
    assign flit_count  = flit_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
